tb_pingpong_sched: RTL and testbench
====================================

// Module: tb_pingpong_sched
// PURPOSE
//  Scheduler for the double-buffered transpose buffer (two halves of NUM_ROWS x FETCH_WIDTH).
//  Sequences row writes into the free half and column reads out of the full half.
//  Tracks per-half ownership (EMPTY/FILLING/FULL/DRAINING) with valid/ready on both sides.
//  Counts inner (columns per half) and outer (halves per job) loops; pulses done at job end.
// PARAMETERS
//  NUM_ROWS    3  rows per half (pixel rows captured before a half is full)
//  FETCH_WIDTH 4  words per row; power of 2; column index wraps modulo FETCH_WIDTH
//  RANGE_W     3  width of cfg_range_inner / cfg_range_outer / cfg_stride
// PORTS
//  clk              in   1        clock
//  rst_n            in   1        reset, asynchronous, active-low
//  start            in   1        1-cycle job start; sampled only in IDLE
//  cfg_range_inner  in   RANGE_W  column reads per half
//  cfg_range_outer  in   RANGE_W  halves per job
//  cfg_stride       in   RANGE_W  column step between reads
//  in_valid         in   1        upstream row available
//  in_ready         out  1        row accepted when in_valid & in_ready
//  wr_en            out  1        = in_valid & in_ready (combinational)
//  wr_buf           out  1        half being written
//  wr_row           out  clog2(NUM_ROWS)      row within wr_buf
//  rd_valid         out  1        column read presented
//  out_ready        in   1        downstream accepts; transfer = rd_valid & out_ready
//  rd_buf           out  1        half being read
//  rd_col           out  clog2(FETCH_WIDTH)   column within rd_buf
//  busy             out  1        job in progress
//  done             out  1        1-cycle pulse after last column of last half transfers
// BEHAVIOUR
//  Reset: IDLE; both halves EMPTY; wr_buf=rd_buf=0; wr_row=rd_col=0; all counters 0;
//   in_ready=rd_valid=busy=done=0. Reset mid-job aborts it; no done pulse.
//  Top FSM IDLE->RUN on start (cfg latched). RUN->IDLE when outer read count reaches
//   range_outer; done=1 that next cycle only. start in RUN ignored.
//  range_inner==0 or range_outer==0: IDLE->RUN->IDLE, done after 2 cycles, no transfers.
//  Write side: in_ready = RUN & half[wr_buf] in {EMPTY,FILLING} & filled_halves<range_outer.
//   Each accept: half->FILLING, wr_row++. Accept at wr_row==NUM_ROWS-1: half->FULL,
//   wr_row<=0, wr_buf toggles, filled_halves++.
//  Read side: rd_valid = RUN & half[rd_buf] in {FULL,DRAINING}. First transfer: ->DRAINING.
//   Each transfer: rd_col <= (rd_col+cfg_stride) mod FETCH_WIDTH, inner++.
//   Transfer at inner==range_inner-1: half->EMPTY, inner<=0, rd_col<=0, rd_buf toggles, outer++.
//  rd_valid stays high while out_ready low; rd_buf/rd_col held stable (no drop on stall).
//  Simultaneous: fill-complete of one half and release of the other in the same cycle both apply.
//  No bypass: a half released in cycle N is writable from cycle N+1 only.
//  Counter arithmetic RANGE_W+1 bits internally; no wrap on range = 2^RANGE_W-1.
// CONFIGURATION
//  TB_PINGPONG_SCHED_PERF_EN defined: adds outputs wr_stall_cnt, rd_stall_cnt (16 b,
//   saturating, cleared on start); count cycles in_valid&~in_ready / rd_valid&~out_ready.
//  Undefined: ports and counters absent; core behaviour identical.
// STRUCTURE
//  Package tb_sched_pkg: sched_state_e {IDLE,RUN}, half_state_e {EMPTY,FILLING,FULL,DRAINING},
//   localparams ROW_W, COL_W.
//  Sub-module tb_sched_loop_cnt: inner/outer counter with last flag; instantiated for
//   read inner, read outer, and write half count.
// TESTING
//  Reset mid-job (after 2 rows): all outputs to reset values, no done, next start clean.
//  range_inner=4,outer=2,stride=1, in_valid=out_ready=1: rd_col 0,1,2,3 per half, rd_buf 0 then 1,
//   done exactly once, 6 writes and 8 reads total.
//  stride=3,inner=4: rd_col sequence 0,3,2,1 (mod-4 wrap).
//  out_ready=0 long: after both halves FULL in_ready=0; rd_buf/rd_col stable; resumes on out_ready.
//  Release of half 0 and fill-complete of half 1 same cycle: half 0 writable next cycle, rd_buf=1.
//  range_outer=0: done pulses 2 cycles after start, in_ready and rd_valid never asserted.

Source files
------------

// File: rtl/tb_sched_pkg.sv
// Shared types and sizing for the ping-pong transpose-buffer scheduler.
// Every scheduler file imports this package.
package tb_sched_pkg;

  localparam int NUM_ROWS    = 3;
  localparam int FETCH_WIDTH = 4;
  localparam int RANGE_W     = 3;
  localparam int ROW_W       = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int COL_W       = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam int CNT_W       = RANGE_W + 1;
  localparam int STALL_W     = 16;

  typedef enum logic {
    IDLE,
    RUN
  } sched_state_e;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    DRAINING
  } half_state_e;

endpackage

// File: rtl/tb_pingpong_sched_if.sv
// Handshake and configuration bundle of the ping-pong scheduler.
// TB_PINGPONG_SCHED_PERF_EN adds the wr/rd stall counter outputs.
interface tb_pingpong_sched_if;
  import tb_sched_pkg::*;

  logic               start;
  logic [RANGE_W-1:0] cfg_range_inner;
  logic [RANGE_W-1:0] cfg_range_outer;
  logic [RANGE_W-1:0] cfg_stride;
  logic               in_valid;
  logic               in_ready;
  logic               wr_en;
  logic               wr_buf;
  logic [ROW_W-1:0]   wr_row;
  logic               rd_valid;
  logic               out_ready;
  logic               rd_buf;
  logic [COL_W-1:0]   rd_col;
  logic               busy;
  logic               done;
`ifdef TB_PINGPONG_SCHED_PERF_EN
  logic [STALL_W-1:0] wr_stall_cnt;
  logic [STALL_W-1:0] rd_stall_cnt;
`endif

  modport master (
    output start, cfg_range_inner, cfg_range_outer, cfg_stride, in_valid, out_ready,
    input  in_ready, wr_en, wr_buf, wr_row, rd_valid, rd_buf, rd_col, busy, done
`ifdef TB_PINGPONG_SCHED_PERF_EN
    , input wr_stall_cnt, rd_stall_cnt
`endif
  );

  modport slave (
    input  start, cfg_range_inner, cfg_range_outer, cfg_stride, in_valid, out_ready,
    output in_ready, wr_en, wr_buf, wr_row, rd_valid, rd_buf, rd_col, busy, done
`ifdef TB_PINGPONG_SCHED_PERF_EN
    , output wr_stall_cnt, rd_stall_cnt
`endif
  );

endinterface

// File: rtl/tb_sched_loop_cnt.sv
// Loop counter for the scheduler, RANGE_W+1 bits wide so that a range of 2^RANGE_W-1 never wraps.
// WRAP=1 flags the final step of a pass; WRAP=0 flags that the count has reached the range.
module tb_sched_loop_cnt
  import tb_sched_pkg::*;
#(
  parameter bit WRAP = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               inc_i,
  input  logic [RANGE_W-1:0] range_i,
  output logic               flag_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] rangeExt;
  logic             isLast;
  logic             isReached;

  assign rangeExt  = {1'b0, range_i};
  assign isLast    = (count_q + CNT_W'(1)) == rangeExt;
  assign isReached = count_q >= rangeExt;
  assign flag_o    = WRAP ? isLast : isReached;

  // Non-wrapping counters saturate at the range so they stay valid until cleared.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i) begin
      if (WRAP && isLast) begin
        count_d = '0;
      end else if (WRAP || !isReached) begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/tb_pingpong_sched.sv
// Ping-pong scheduler: fills one half of the transpose buffer row by row while draining the other by column.
// TB_PINGPONG_SCHED_PERF_EN adds saturating input/output stall counters, cleared on start.
module tb_pingpong_sched
  import tb_sched_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  tb_pingpong_sched_if.slave bus
);

  sched_state_e       state_q, state_d;
  half_state_e        half_q [2];
  half_state_e        half_d [2];
  logic [RANGE_W-1:0] rangeInner_q, rangeInner_d;
  logic [RANGE_W-1:0] rangeOuter_q, rangeOuter_d;
  logic [RANGE_W-1:0] stride_q, stride_d;
  logic               wrBuf_q, wrBuf_d;
  logic [ROW_W-1:0]   wrRow_q, wrRow_d;
  logic               rdBuf_q, rdBuf_d;
  logic [COL_W-1:0]   rdCol_q, rdCol_d;
  logic               done_q, done_d;

  logic               idle, running, jobEmpty, finish;
  logic               inReady, wrEn, rowLast, rdValid, rdXfer;
  logic               innerLast, outerDone, wrHalvesDone;
  logic [COL_W-1:0]   strideCol;

  assign idle      = (state_q == IDLE);
  assign running   = (state_q == RUN);
  assign jobEmpty  = (rangeInner_q == '0);
  assign finish    = running && (jobEmpty || outerDone);
  assign rowLast   = (wrRow_q == ROW_W'(NUM_ROWS - 1));
  assign strideCol = COL_W'(stride_q);

  assign inReady = running && !jobEmpty && !wrHalvesDone &&
                   ((half_q[wrBuf_q] == EMPTY) || (half_q[wrBuf_q] == FILLING));
  assign wrEn    = bus.in_valid && inReady;
  assign rdValid = running && ((half_q[rdBuf_q] == FULL) || (half_q[rdBuf_q] == DRAINING));
  assign rdXfer  = rdValid && bus.out_ready;

  tb_sched_loop_cnt #(.WRAP(1'b1)) uReadInner (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (idle),
    .inc_i   (rdXfer),
    .range_i (rangeInner_q),
    .flag_o  (innerLast)
  );

  tb_sched_loop_cnt #(.WRAP(1'b0)) uReadOuter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (idle),
    .inc_i   (rdXfer && innerLast),
    .range_i (rangeOuter_q),
    .flag_o  (outerDone)
  );

  tb_sched_loop_cnt #(.WRAP(1'b0)) uWriteHalves (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (idle),
    .inc_i   (wrEn && rowLast),
    .range_i (rangeOuter_q),
    .flag_o  (wrHalvesDone)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (finish)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Idle holds the datapath at its reset picture; write and read sides never touch the same half.
  always_comb begin
    half_d       = half_q;
    rangeInner_d = rangeInner_q;
    rangeOuter_d = rangeOuter_q;
    stride_d     = stride_q;
    wrBuf_d      = wrBuf_q;
    wrRow_d      = wrRow_q;
    rdBuf_d      = rdBuf_q;
    rdCol_d      = rdCol_q;
    done_d       = finish;
    if (idle) begin
      half_d[0] = EMPTY;
      half_d[1] = EMPTY;
      wrBuf_d   = 1'b0;
      wrRow_d   = '0;
      rdBuf_d   = 1'b0;
      rdCol_d   = '0;
      if (bus.start) begin
        rangeInner_d = bus.cfg_range_inner;
        rangeOuter_d = bus.cfg_range_outer;
        stride_d     = bus.cfg_stride;
      end
    end else begin
      if (wrEn) begin
        if (rowLast) begin
          half_d[wrBuf_q] = FULL;
          wrRow_d         = '0;
          wrBuf_d         = ~wrBuf_q;
        end else begin
          half_d[wrBuf_q] = FILLING;
          wrRow_d         = wrRow_q + ROW_W'(1);
        end
      end
      if (rdXfer) begin
        if (innerLast) begin
          half_d[rdBuf_q] = EMPTY;
          rdCol_d         = '0;
          rdBuf_d         = ~rdBuf_q;
        end else begin
          half_d[rdBuf_q] = DRAINING;
          rdCol_d         = rdCol_q + strideCol;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      half_q[0]    <= EMPTY;
      half_q[1]    <= EMPTY;
      rangeInner_q <= '0;
      rangeOuter_q <= '0;
      stride_q     <= '0;
      wrBuf_q      <= 1'b0;
      wrRow_q      <= '0;
      rdBuf_q      <= 1'b0;
      rdCol_q      <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      half_q       <= half_d;
      rangeInner_q <= rangeInner_d;
      rangeOuter_q <= rangeOuter_d;
      stride_q     <= stride_d;
      wrBuf_q      <= wrBuf_d;
      wrRow_q      <= wrRow_d;
      rdBuf_q      <= rdBuf_d;
      rdCol_q      <= rdCol_d;
      done_q       <= done_d;
    end
  end

  assign bus.in_ready = inReady;
  assign bus.wr_en    = wrEn;
  assign bus.wr_buf   = wrBuf_q;
  assign bus.wr_row   = wrRow_q;
  assign bus.rd_valid = rdValid;
  assign bus.rd_buf   = rdBuf_q;
  assign bus.rd_col   = rdCol_q;
  assign bus.busy     = running;
  assign bus.done     = done_q;

`ifdef TB_PINGPONG_SCHED_PERF_EN
  logic [STALL_W-1:0] wrStall_q, rdStall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrStall_q <= '0;
      rdStall_q <= '0;
    end else if (idle && bus.start) begin
      wrStall_q <= '0;
      rdStall_q <= '0;
    end else begin
      if (bus.in_valid && !inReady && (wrStall_q != '1)) wrStall_q <= wrStall_q + STALL_W'(1);
      if (rdValid && !bus.out_ready && (rdStall_q != '1)) rdStall_q <= rdStall_q + STALL_W'(1);
    end
  end

  assign bus.wr_stall_cnt = wrStall_q;
  assign bus.rd_stall_cnt = rdStall_q;
`endif

endmodule

// File: tb/tb_tb_pingpong_sched.sv
// Self-checking bench for tb_pingpong_sched: a count-based model of rows written and columns
// read predicts every handshake output cycle by cycle under randomized valid/ready traffic.
module tb_tb_pingpong_sched;
  import tb_sched_pkg::*;

  localparam int BUDGET = 3000;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   dutWr, dutRd, dutDones;
  int   dutCols[$];

  always #5 clk = ~clk;

  tb_pingpong_sched_if bus ();

  tb_pingpong_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Job model: half h gets rows h*NUM_ROWS.., is readable once all its rows are in, and
  // half h is writable once half h-2 has delivered all its columns in an earlier cycle.
  task automatic runJob(input int inner, input int outer, input int stride, input int validPct,
                        input int readyPct, input int stallCycles, input bit randStart);
    int nWr = 0;
    int nRd = 0;
    int afterLast;
    int wHalf, rHalf, expCol;
    bit expIn, expRd, expBusy, expDone, wrX, rdX;
`ifdef TB_PINGPONG_SCHED_PERF_EN
    int wrStall = 0;
    int rdStall = 0;
`endif
    dutWr = 0;
    dutRd = 0;
    dutDones = 0;
    dutCols.delete();
    @(negedge clk);
    bus.start           = 1'b1;
    bus.cfg_range_inner = RANGE_W'(inner);
    bus.cfg_range_outer = RANGE_W'(outer);
    bus.cfg_stride      = RANGE_W'(stride);
    bus.in_valid        = 1'b0;
    bus.out_ready       = 1'b0;
    afterLast = (inner == 0 || outer == 0) ? 0 : -1;
    for (int cyc = 1; cyc <= BUDGET; cyc++) begin
      @(negedge clk);
      if (afterLast >= 0) afterLast++;
      bus.start = (randStart && afterLast < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (randStart) begin
        bus.cfg_range_inner = RANGE_W'($urandom);
        bus.cfg_range_outer = RANGE_W'($urandom);
        bus.cfg_stride      = RANGE_W'($urandom);
      end
      bus.in_valid  = ($urandom_range(1, 100) <= validPct);
      bus.out_ready = (cyc > stallCycles) && ($urandom_range(1, 100) <= readyPct);
      #1;
      wHalf   = nWr / NUM_ROWS;
      rHalf   = (inner > 0) ? nRd / inner : 0;
      expBusy = (afterLast < 2);
      expDone = (afterLast == 2);
      expIn   = expBusy && inner > 0 && wHalf < outer && (wHalf < 2 || nRd >= (wHalf - 1) * inner);
      expRd   = expBusy && inner > 0 && rHalf < outer && nWr >= (rHalf + 1) * NUM_ROWS;
      expCol  = (inner > 0) ? ((nRd % inner) * stride) % FETCH_WIDTH : 0;

      checks++;
      if (bus.busy !== expBusy) begin
        errors++;
        $display("[TB] FAIL busy cyc=%0d: got %b expected %b", cyc, bus.busy, expBusy);
      end
      checks++;
      if (bus.done !== expDone) begin
        errors++;
        $display("[TB] FAIL done cyc=%0d: got %b expected %b", cyc, bus.done, expDone);
      end
      checks++;
      if (bus.in_ready !== expIn) begin
        errors++;
        $display("[TB] FAIL in_ready cyc=%0d: got %b expected %b", cyc, bus.in_ready, expIn);
      end
      checks++;
      if (bus.wr_en !== (bus.in_valid && expIn)) begin
        errors++;
        $display("[TB] FAIL wr_en cyc=%0d: got %b expected %b", cyc, bus.wr_en, bus.in_valid && expIn);
      end
      checks++;
      if (bus.rd_valid !== expRd) begin
        errors++;
        $display("[TB] FAIL rd_valid cyc=%0d: got %b expected %b", cyc, bus.rd_valid, expRd);
      end
      if (expIn) begin
        checks++;
        if (bus.wr_buf !== 1'(wHalf % 2) || bus.wr_row !== ROW_W'(nWr % NUM_ROWS)) begin
          errors++;
          $display("[TB] FAIL wr_pos cyc=%0d: got buf=%0d row=%0d expected buf=%0d row=%0d",
                   cyc, bus.wr_buf, bus.wr_row, wHalf % 2, nWr % NUM_ROWS);
        end
      end
      if (expRd) begin
        checks++;
        if (bus.rd_buf !== 1'(rHalf % 2) || bus.rd_col !== COL_W'(expCol)) begin
          errors++;
          $display("[TB] FAIL rd_pos cyc=%0d: got buf=%0d col=%0d expected buf=%0d col=%0d",
                   cyc, bus.rd_buf, bus.rd_col, rHalf % 2, expCol);
        end
      end
`ifdef TB_PINGPONG_SCHED_PERF_EN
      checks++;
      if (bus.wr_stall_cnt !== STALL_W'(wrStall) || bus.rd_stall_cnt !== STALL_W'(rdStall)) begin
        errors++;
        $display("[TB] FAIL stall_cnt cyc=%0d: got wr=%0d rd=%0d expected wr=%0d rd=%0d",
                 cyc, bus.wr_stall_cnt, bus.rd_stall_cnt, wrStall, rdStall);
      end
      wrStall += (bus.in_valid && !expIn) ? 1 : 0;
      rdStall += (expRd && !bus.out_ready) ? 1 : 0;
`endif
      if (bus.done === 1'b1) dutDones++;
      if (bus.wr_en === 1'b1) dutWr++;
      if (bus.rd_valid === 1'b1 && bus.out_ready) begin
        dutRd++;
        dutCols.push_back(int'(bus.rd_col));
      end
      wrX = bus.in_valid && expIn;
      rdX = expRd && bus.out_ready;
      if (wrX) nWr++;
      if (rdX) begin
        nRd++;
        if (nRd == outer * inner) afterLast = 0;
      end
      if (afterLast == 2) break;
    end
    if (afterLast != 2) begin
      checks++;
      errors++;
      $display("[TB] FAIL job_timeout: got no completion expected done within %0d cycles", BUDGET);
    end
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_done: got done=%b busy=%b expected 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic checkTotals(input string name, input int expWr, input int expRd);
    checks++;
    if (dutWr != expWr || dutRd != expRd || dutDones != 1) begin
      errors++;
      $display("[TB] FAIL %s totals: got wr=%0d rd=%0d done=%0d expected wr=%0d rd=%0d done=1",
               name, dutWr, dutRd, dutDones, expWr, expRd);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.cfg_range_inner = '0;
    bus.cfg_range_outer = '0;
    bus.cfg_stride = '0;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.in_ready, bus.rd_valid, bus.wr_en, bus.wr_buf, bus.rd_buf,
         bus.wr_row, bus.rd_col} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got nonzero expected all zero");
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_job();
    @(negedge clk);
    bus.start = 1'b1;
    bus.cfg_range_inner = 3'd4;
    bus.cfg_range_outer = 3'd2;
    bus.cfg_stride = 3'd1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.wr_row !== ROW_W'(2) || bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_job_progress: got row=%0d busy=%b expected row=2 busy=1", bus.wr_row, bus.busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.in_ready, bus.rd_valid, bus.wr_en, bus.wr_buf, bus.rd_buf,
         bus.wr_row, bus.rd_col} !== '0) begin
      errors++;
      $display("[TB] FAIL mid_job_reset: got nonzero expected all zero");
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL mid_job_no_done: got done=%b busy=%b expected 0 0", bus.done, bus.busy);
      end
    end
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    runJob(4, 2, 1, 100, 100, 0, 1'b0);
    checkTotals("after_reset", 6, 8);
  endtask

  task automatic test_basic();
    int expCols[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    runJob(4, 2, 1, 100, 100, 0, 1'b0);
    checkTotals("basic", 6, 8);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= dutCols.size() || dutCols[i] != expCols[i]) begin
        errors++;
        $display("[TB] FAIL basic_col[%0d]: got %0d expected %0d", i,
                 (i < dutCols.size()) ? dutCols[i] : -1, expCols[i]);
      end
    end
  endtask

  task automatic test_stride();
    int expCols[4] = '{0, 3, 2, 1};
    runJob(4, 1, 3, 100, 100, 0, 1'b0);
    checkTotals("stride", 3, 4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= dutCols.size() || dutCols[i] != expCols[i]) begin
        errors++;
        $display("[TB] FAIL stride_col[%0d]: got %0d expected %0d", i,
                 (i < dutCols.size()) ? dutCols[i] : -1, expCols[i]);
      end
    end
  endtask

  task automatic test_stall();
    runJob(4, 3, 1, 100, 100, 25, 1'b0);
    checkTotals("stall", 9, 12);
  endtask

  task automatic test_back_to_back();
    runJob(3, 3, 1, 100, 100, 0, 1'b0);
    checkTotals("back_to_back", 9, 9);
    runJob(7, 7, 5, 100, 100, 0, 1'b0);
    checkTotals("max_range", 21, 49);
  endtask

  task automatic test_empty();
    runJob(3, 0, 1, 100, 100, 0, 1'b0);
    checkTotals("outer_zero", 0, 0);
    runJob(0, 2, 1, 100, 100, 0, 1'b0);
    checkTotals("inner_zero", 0, 0);
  endtask

  task automatic test_random();
    int inner, outer;
    for (int j = 0; j < 8; j++) begin
      inner = $urandom_range(1, 7);
      outer = $urandom_range(1, 7);
      runJob(inner, outer, $urandom_range(0, 7), $urandom_range(30, 100),
             $urandom_range(30, 100), $urandom_range(0, 10), 1'b1);
      checkTotals("random", outer * NUM_ROWS, outer * inner);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_job();
    test_basic();
    test_stride();
    test_stall();
    test_back_to_back();
    test_empty();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
